// File: rtl/axi_gpu_pkg.sv
// Shared burst/response encodings and FSM state types for axi_gpu_burst_mem.
// WRAP burst support is enabled by defining AXI_GPU_WRAP_EN.
package axi_gpu_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage

// File: rtl/axi_gpu_burst_addr.sv
// Per-beat address step, word index, last-beat and error decode for one AXI channel.
// WRAP bursts are legal only when AXI_GPU_WRAP_EN is defined.
module axi_gpu_burst_addr
  import axi_gpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_BYTES = 8192,
  localparam int unsigned NB       = DATA_W / 8,
  localparam int unsigned LNB      = $clog2(NB),
  localparam int unsigned WIDX_W   = $clog2(MEM_BYTES / NB)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        len,
  input  logic [7:0]        cnt,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic [WIDX_W-1:0] word_idx,
  output logic              beat_err,
  output logic              last_beat
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] incr_addr;
  logic              bad_burst;
`ifdef AXI_GPU_WRAP_EN
  logic [ADDR_W-1:0] wrap_mask;
`endif

  always_comb begin
    offset    = addr - base;
    incr_addr = (addr & ~ADDR_W'(NB - 1)) + ADDR_W'(NB);
    word_idx  = offset[LNB +: WIDX_W];
    last_beat = (cnt == len);
`ifdef AXI_GPU_WRAP_EN
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << LNB) - ADDR_W'(1);
    bad_burst = (burst == 2'b11) ||
                ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
`else
    bad_burst = (burst == BURST_WRAP) || (burst == 2'b11);
`endif
    // Evaluated per beat so an INCR burst running past the top errors only its tail.
    beat_err  = bad_burst || (addr < base) || (offset >= ADDR_W'(MEM_BYTES)) ||
                (size != 3'(LNB));
    case (burst)
      BURST_INCR: next_addr = incr_addr;
`ifdef AXI_GPU_WRAP_EN
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_gpu_burst_mem.sv
// AXI4 burst memory slave with independent write/read FSMs and a saturating SLVERR counter.
// Define AXI_GPU_WRAP_EN to accept WRAP bursts (LEN 1/3/7/15).
module axi_gpu_burst_mem
  import axi_gpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       MEM_BYTES = 8192,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       ERRCNT_W  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_W-1:0]       S_AWID,
  input  logic [ADDR_W-1:0]     S_AWADDR,
  input  logic [7:0]            S_AWLEN,
  input  logic [2:0]            S_AWSIZE,
  input  logic [1:0]            S_AWBURST,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [DATA_W-1:0]     S_WDATA,
  input  logic [DATA_W/8-1:0]   S_WSTRB,
  input  logic                  S_WLAST,
  input  logic                  S_WVALID,
  output logic                  S_WREADY,
  output logic [ID_W-1:0]       S_BID,
  output logic [1:0]            S_BRESP,
  output logic                  S_BVALID,
  input  logic                  S_BREADY,
  input  logic [ID_W-1:0]       S_ARID,
  input  logic [ADDR_W-1:0]     S_ARADDR,
  input  logic [7:0]            S_ARLEN,
  input  logic [2:0]            S_ARSIZE,
  input  logic [1:0]            S_ARBURST,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  output logic [ID_W-1:0]       S_RID,
  output logic [DATA_W-1:0]     S_RDATA,
  output logic [1:0]            S_RRESP,
  output logic                  S_RLAST,
  output logic                  S_RVALID,
  input  logic                  S_RREADY,
  output logic [ERRCNT_W-1:0]   err_count
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned WORDS  = MEM_BYTES / NB;
  localparam int unsigned WIDX_W = $clog2(WORDS);

  logic [DATA_W-1:0] mem_q [WORDS];

  logic              live_q;
  wstate_e           wstate_q, wstate_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic              werr_q, werr_d;
  logic              mem_we;

  rstate_e           rstate_q, rstate_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic              fetch;

  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  logic [ERRCNT_W:0]   err_sum;

  logic [ADDR_W-1:0] w_next, r_next, ru_addr;
  logic [WIDX_W-1:0] w_idx, r_idx;
  logic              w_err, w_last, r_err, r_last;
  logic [7:0]        ru_len, ru_cnt;
  logic [2:0]        ru_size;
  logic [1:0]        ru_burst;

  axi_gpu_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) u_waddr (
    .addr(waddr_q), .base(BASE_ADDR), .len(wlen_q), .cnt(wcnt_q), .size(wsize_q),
    .burst(wburst_q), .next_addr(w_next), .word_idx(w_idx), .beat_err(w_err),
    .last_beat(w_last)
  );

  // While idle the read unit decodes the incoming AR so beat 0 is fetched on the handshake.
  always_comb begin
    if (rstate_q == R_IDLE) begin
      ru_addr  = S_ARADDR;
      ru_len   = S_ARLEN;
      ru_size  = S_ARSIZE;
      ru_burst = S_ARBURST;
      ru_cnt   = '0;
    end else begin
      ru_addr  = raddr_q;
      ru_len   = rlen_q;
      ru_size  = rsize_q;
      ru_burst = rburst_q;
      ru_cnt   = rcnt_q + 8'd1;
    end
  end

  axi_gpu_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) u_raddr (
    .addr(ru_addr), .base(BASE_ADDR), .len(ru_len), .cnt(ru_cnt), .size(ru_size),
    .burst(ru_burst), .next_addr(r_next), .word_idx(r_idx), .beat_err(r_err),
    .last_beat(r_last)
  );

  always_comb begin
    wstate_d = wstate_q;
    wid_d    = wid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    werr_d   = werr_q;
    mem_we   = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        if (S_AWVALID && live_q) begin
          wid_d    = S_AWID;
          waddr_d  = S_AWADDR;
          wlen_d   = S_AWLEN;
          wsize_d  = S_AWSIZE;
          wburst_d = S_AWBURST;
          wcnt_d   = '0;
          werr_d   = 1'b0;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_WVALID) begin
          mem_we  = !w_err;
          waddr_d = w_next;
          wcnt_d  = wcnt_q + 8'd1;
          if (w_err || (S_WLAST != w_last)) werr_d = 1'b1;
          if (w_last) wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    fetch    = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        if (S_ARVALID && live_q) begin
          rid_d    = S_ARID;
          rlen_d   = S_ARLEN;
          rsize_d  = S_ARSIZE;
          rburst_d = S_ARBURST;
          rcnt_d   = '0;
          fetch    = 1'b1;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_RREADY) begin
          if (rlast_q) begin
            rstate_d = R_IDLE;
          end else begin
            rcnt_d = rcnt_q + 8'd1;
            fetch  = 1'b1;
          end
        end
      end
    endcase
    if (fetch) begin
      raddr_d = r_next;
      rdata_d = r_err ? '0 : mem_q[r_idx];
      rresp_d = r_err ? RESP_SLVERR : RESP_OKAY;
      rlast_d = r_last;
    end
  end

  always_comb begin
    err_sum  = {1'b0, errcnt_q}
             + {{ERRCNT_W{1'b0}}, S_BVALID && S_BREADY && werr_q}
             + {{ERRCNT_W{1'b0}}, S_RVALID && S_RREADY && (rresp_q == RESP_SLVERR)};
    errcnt_d = err_sum[ERRCNT_W] ? '1 : err_sum[ERRCNT_W-1:0];
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (S_WSTRB[k]) mem_q[w_idx][k*8 +: 8] <= S_WDATA[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      live_q   <= 1'b0;
      wstate_q <= W_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      werr_q   <= 1'b0;
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
      errcnt_q <= '0;
    end else begin
      live_q   <= 1'b1;
      wstate_q <= wstate_d;
      wid_q    <= wid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      werr_q   <= werr_d;
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      errcnt_q <= errcnt_d;
    end
  end

  // live_q keeps both address READYs low while reset is asserted.
  assign S_AWREADY = (wstate_q == W_IDLE) && live_q;
  assign S_WREADY  = (wstate_q == W_DATA);
  assign S_BVALID  = (wstate_q == W_RESP);
  assign S_BID     = wid_q;
  assign S_BRESP   = werr_q ? RESP_SLVERR : RESP_OKAY;
  assign S_ARREADY = (rstate_q == R_IDLE) && live_q;
  assign S_RVALID  = (rstate_q == R_DATA);
  assign S_RID     = rid_q;
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;
  assign S_RLAST   = rlast_q;
  assign err_count = errcnt_q;

endmodule

// File: tb/tb_axi_gpu_burst_mem.sv
// Directed bench for axi_gpu_burst_mem: byte-array memory model, expected-beat queues and a
// negedge compare process, plus literal expectations for the documented scenarios.
module tb_axi_gpu_burst_mem;

  localparam int unsigned MB = 8192;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  S_AWID = '0, S_ARID = '0;
  logic [31:0] S_AWADDR = '0, S_ARADDR = '0;
  logic [7:0]  S_AWLEN = '0, S_ARLEN = '0;
  logic [2:0]  S_AWSIZE = '0, S_ARSIZE = '0;
  logic [1:0]  S_AWBURST = '0, S_ARBURST = '0;
  logic        S_AWVALID = 1'b0, S_ARVALID = 1'b0;
  logic [63:0] S_WDATA = '0;
  logic [7:0]  S_WSTRB = '0;
  logic        S_WLAST = 1'b0, S_WVALID = 1'b0, S_BREADY = 1'b0, S_RREADY = 1'b0;
  logic        S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RLAST, S_RVALID;
  logic [3:0]  S_BID, S_RID;
  logic [1:0]  S_BRESP, S_RRESP;
  logic [63:0] S_RDATA;
  logic [15:0] err_count;

  axi_gpu_burst_mem #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_BYTES(MB), .BASE_ADDR(32'h0), .ERRCNT_W(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
    .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
    .S_WREADY(S_WREADY), .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID),
    .S_BREADY(S_BREADY), .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
    .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID),
    .S_ARREADY(S_ARREADY), .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
    .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .err_count(err_count)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

  int          checks = 0;
  int          errors = 0;
  int          exp_err = 0;
  rbeat_t      rq[$];
  bresp_t      bq[$];
  logic [63:0] got[$];
  logic [7:0]  mem_m [MB];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [1:0] burst);
    if (burst == 2'b01 && i > 0) return (a & ~32'h7) + 32'(i) * 32'd8;
    return a;
  endfunction

  function automatic bit beat_ok(input logic [31:0] a, input logic [2:0] size,
                                 input logic [1:0] burst);
    return (a < 32'(MB)) && (size == 3'd3) && (burst <= 2'b01);
  endfunction

  function automatic logic [63:0] model_word(input logic [31:0] a);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = mem_m[int'((a & ~32'h7) + 32'(b))];
    return w;
  endfunction

  // Compare process: every cycle outputs are meaningful, against the queued expectations.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      rq.delete();
      bq.delete();
      exp_err = 0;
      chk("rst_rvalid", 64'(S_RVALID), 64'd0);
      chk("rst_bvalid", 64'(S_BVALID), 64'd0);
      chk("rst_awready", 64'(S_AWREADY), 64'd0);
      chk("rst_arready", 64'(S_ARREADY), 64'd0);
      chk("rst_rdata", S_RDATA, 64'd0);
      chk("rst_rlast", 64'(S_RLAST), 64'd0);
      chk("rst_bresp", 64'(S_BRESP), 64'd0);
      chk("rst_errcnt", 64'(err_count), 64'd0);
    end else begin
      chk("err_count", 64'(err_count), 64'(exp_err));
      if (S_RVALID) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          chk("rid", 64'(S_RID), 64'(rq[0].id));
          chk("rdata", S_RDATA, rq[0].data);
          chk("rresp", 64'(S_RRESP), 64'(rq[0].resp));
          chk("rlast", 64'(S_RLAST), 64'(rq[0].last));
          chk("arready_busy", 64'(S_ARREADY), 64'd0);
          if (S_RREADY) begin
            got.push_back(S_RDATA);
            if (rq[0].resp == 2'b10) exp_err++;
            void'(rq.pop_front());
          end
        end
      end
      if (S_BVALID) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bvalid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          chk("bid", 64'(S_BID), 64'(bq[0].id));
          chk("bresp", 64'(S_BRESP), 64'(bq[0].resp));
          if (S_BREADY) begin
            if (bq[0].resp == 2'b10) exp_err++;
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  // Returns at posedge+1 after the edge on which the handshake completed.
  task automatic hs_wait(input int which, input string name);
    bit hs;
    int n;
    n = 0;
    do begin
      @(negedge ACLK);
      case (which)
        0:       hs = S_AWREADY;
        1:       hs = S_WREADY;
        default: hs = S_ARREADY;
      endcase
      @(posedge ACLK);
      #1;
      n++;
    end while (!hs && n < 200);
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no handshake expected handshake", name);
    end
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input logic [63:0] dbase, input logic [7:0] strb, input int last_at);
    bit          err;
    logic [31:0] a;
    logic [63:0] dv;
    int          n;
    err = 0;
    for (int i = 0; i <= len; i++) begin
      a  = beat_addr(addr, i, burst);
      dv = dbase + 64'(i);
      if (beat_ok(a, size, burst)) begin
        for (int b = 0; b < 8; b++)
          if (strb[b]) mem_m[int'((a & ~32'h7) + 32'(b))] = dv[b*8 +: 8];
      end else begin
        err = 1;
      end
      if ((i == last_at) != (i == len)) err = 1;
    end
    bq.push_back(bresp_t'{id: id, resp: err ? 2'b10 : 2'b00});
    S_AWID = id; S_AWADDR = addr; S_AWLEN = 8'(len); S_AWSIZE = size; S_AWBURST = burst;
    S_AWVALID = 1'b1;
    hs_wait(0, "aw");
    S_AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      S_WDATA = dbase + 64'(i);
      S_WSTRB = strb;
      S_WLAST = (i == last_at);
      S_WVALID = 1'b1;
      hs_wait(1, "w");
      S_WVALID = 1'b0;
    end
    S_WLAST = 1'b0;
    S_BREADY = 1'b1;
    n = 0;
    while (bq.size() != 0 && n < 200) begin
      @(posedge ACLK);
      n++;
    end
    #1;
    S_BREADY = 1'b0;
    if (bq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_b: got no response expected response");
    end
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input int stall);
    logic [31:0] a;
    bit          ok;
    int          n;
    got.delete();
    for (int i = 0; i <= len; i++) begin
      a  = beat_addr(addr, i, burst);
      ok = beat_ok(a, size, burst);
      rq.push_back(rbeat_t'{id: id, data: ok ? model_word(a) : 64'd0,
                            resp: ok ? 2'b00 : 2'b10, last: (i == len)});
    end
    S_ARID = id; S_ARADDR = addr; S_ARLEN = 8'(len); S_ARSIZE = size; S_ARBURST = burst;
    S_ARVALID = 1'b1;
    hs_wait(2, "ar");
    S_ARVALID = 1'b0;
    S_RREADY = (stall == 0);
    @(negedge ACLK);
    chk("rvalid_latency", 64'(S_RVALID), 64'd1);
    if (stall > 0) begin
      repeat (stall) @(posedge ACLK);
      #1;
      S_RREADY = 1'b1;
    end
    n = 0;
    while (rq.size() != 0 && n < 300) begin
      @(posedge ACLK);
      n++;
    end
    #1;
    S_RREADY = 1'b0;
    if (rq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_r: got %0d beats left expected 0", rq.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(MB); i++) mem_m[i] = 8'h00;
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    chk("post_rst_awready", 64'(S_AWREADY), 64'd1);

    // INCR write and read-back with ID echo
    write_burst(4'h3, 32'h1000, 3, 2'b01, 3'd3, 64'hA0, 8'hFF, 3);
    read_burst(4'h5, 32'h1000, 3, 2'b01, 3'd3, 0);
    chk("t1_nbeats", 64'(got.size()), 64'd4);
    chk("t1_beat0", got[0], 64'hA0);
    chk("t1_beat3", got[3], 64'hA3);

    // byte strobes
    write_burst(4'h1, 32'h0800, 0, 2'b01, 3'd3, 64'hFACECAFEDEADBEEF, 8'hFF, 0);
    write_burst(4'h2, 32'h0800, 0, 2'b01, 3'd3, 64'h1111111111111111, 8'h0F, 0);
    read_burst(4'h2, 32'h0800, 0, 2'b01, 3'd3, 0);
    chk("t2_strobe", got[0], 64'hFACECAFE11111111);

    // burst running off the top of memory
    read_burst(4'h7, 32'h1FF0, 3, 2'b01, 3'd3, 0);
    chk("t3_beat2_zero", got[2], 64'd0);
    chk("t3_errcnt", 64'(err_count), 64'd2);

    // early WLAST: all beats written, SLVERR response
    write_burst(4'h9, 32'h0300, 2, 2'b01, 3'd3, 64'hC0, 8'hFF, 1);
    chk("t4_errcnt", 64'(err_count), 64'd3);
    read_burst(4'h9, 32'h0300, 2, 2'b01, 3'd3, 0);
    chk("t4_beat1", got[1], 64'hC1);

    // FIXED burst: last beat wins
    write_burst(4'hA, 32'h0400, 2, 2'b00, 3'd3, 64'hD0, 8'hFF, 2);
    read_burst(4'hA, 32'h0400, 0, 2'b01, 3'd3, 0);
    chk("fixed_last", got[0], 64'hD2);

    // WRAP without the feature: every beat SLVERR, no writes; bad size also errors
    read_burst(4'hB, 32'h1000, 3, 2'b10, 3'd3, 0);
    write_burst(4'hB, 32'h1000, 1, 2'b10, 3'd3, 64'h55, 8'hFF, 1);
    read_burst(4'hC, 32'h1000, 0, 2'b01, 3'd2, 0);
    chk("wrap_size_errcnt", 64'(err_count), 64'd9);
    read_burst(4'hC, 32'h1000, 0, 2'b01, 3'd3, 0);
    chk("wrap_nowrite", got[0], 64'hA0);

    // concurrent write and stalled read
    write_burst(4'h4, 32'h0200, 3, 2'b01, 3'd3, 64'hE0, 8'hFF, 3);
    fork
      write_burst(4'h6, 32'h0100, 1, 2'b01, 3'd3, 64'h77, 8'hFF, 1);
      read_burst(4'h8, 32'h0200, 3, 2'b01, 3'd3, 5);
    join
    chk("t5_beat0", got[0], 64'hE0);
    chk("t5_beat3", got[3], 64'hE3);
    read_burst(4'h6, 32'h0100, 1, 2'b01, 3'd3, 0);
    chk("t5_write", got[1], 64'h78);

    // reset in the middle of a read burst
    for (int i = 0; i <= 7; i++)
      rq.push_back(rbeat_t'{id: 4'hD, data: model_word(32'h1000 + 32'(i) * 32'd8),
                            resp: 2'b00, last: (i == 7)});
    S_ARID = 4'hD; S_ARADDR = 32'h1000; S_ARLEN = 8'd7; S_ARSIZE = 3'd3; S_ARBURST = 2'b01;
    S_ARVALID = 1'b1;
    hs_wait(2, "ar_rst");
    S_ARVALID = 1'b0;
    S_RREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b0;
    #1 chk("rst_rvalid_async", 64'(S_RVALID), 64'd0);
    S_RREADY = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rel_awready", 64'(S_AWREADY), 64'd1);
    chk("rel_arready", 64'(S_ARREADY), 64'd1);
    chk("rel_errcnt", 64'(err_count), 64'd0);
    read_burst(4'hE, 32'h1000, 3, 2'b01, 3'd3, 0);
    chk("t6_retained0", got[0], 64'hA0);
    chk("t6_retained3", got[3], 64'hA3);

    repeat (3) @(posedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
